packet_buffer_read_arbiter: RTL and testbench
=============================================

// Module: packet_buffer_read_arbiter
// PURPOSE
//  Shares the single read port of packet_buffer_ram_driver between two requesters:
//  port 0 = Ethernet transmit path (packet synth), port 1 = UART dump (stream_from_memory).
//  Round-robin grant, at most one RAM read issued per cycle.
//  Tags each read in flight so the returning byte is routed back to its issuer.
//  Sits between the requesters and the RAM driver in main; replaces the direct UART hookup.
// PARAMETERS
//  RAM_SIZE      PACKET_BUFFER_SIZE  RAM depth; address width = clog2(RAM_SIZE)
//  READ_LATENCY  2                   cycles from ram_read_req to ram_read_ready (>=1)
//  WORD_LEN      BYTE_LEN            data width
// PORTS
//  clk             in   1      system clock (50 MHz)
//  reset           in   1      asynchronous, active-low reset
//  req0, req1      in   1      read request, level; hold with addr stable until gnt
//  addr0, addr1    in   AW     read address, AW = clog2(RAM_SIZE)
//  gnt0, gnt1      out  1      combinational grant; the read is issued this cycle
//  ready0, ready1  out  1      registered one-cycle pulse: data valid on dataN
//  data0, data1    out  WORD_LEN  registered read data
//  ram_read_req    out  1      to RAM driver; = gnt0|gnt1
//  ram_read_addr   out  AW     address of granted port; 0 when idle
//  ram_read_ready  in   1      from RAM driver
//  ram_read_out    in   WORD_LEN  from RAM driver
//  err             out  1      sticky: ram_read_ready arrived with no read in flight
// BEHAVIOUR
//  Reset (reset==0, async): gnt*/ready* = 0, data* = 0, err = 0, tag pipe cleared,
//   last-grant pointer = 1 (port 0 wins the first tie).
//  Arbitration (same cycle): only reqN -> gntN. Both -> grant port != last;
//   last updates to the granted port on every grant. Never both grants high.
//  Tag pipe: READ_LATENCY-deep shift reg of {valid,id}; entry pushed on each grant,
//   shifts every cycle. Tail entry pairs with ram_read_ready.
//  Return: ram_read_ready & tail.valid -> next cycle ready[tail.id]=1,
//   data[tail.id]=ram_read_out. End-to-end latency gnt->ready = READ_LATENCY+1.
//  dataN holds its last value between ready pulses; other port's data unchanged.
//  ram_read_ready & !tail.valid -> data dropped, err=1 until reset.
//  tail.valid & !ram_read_ready -> tag dropped, err=1 (driver latency mismatch).
//  Back-to-back: a port holding req gets a grant every cycle when alone; when both
//   hold req, grants alternate 0,1,0,1... Throughput 1 read/cycle total.
//  reqN dropped before gnt: no read, no state change. Address wrap is the
//   requester's job; addr >= RAM_SIZE passed through unchecked.
//  Reset mid-operation: in-flight reads discarded; late ram_read_ready after reset
//   release with empty pipe sets err (bench holds reset >= READ_LATENCY cycles).
// CONFIGURATION
//  PB_ARB_LOCK_EN defined: adds inputs lock0, lock1 (1 bit). While the last-granted
//   port holds its lock and req, it keeps priority (other port starved); lock
//   ignored on the non-owner port; dropping lock resumes round-robin next cycle.
//  PB_ARB_LOCK_EN undefined: no lock ports, pure round-robin as above.
// TESTING
//  Single port 0, addr 5, RAM byte 8'hA5 -> gnt0 same cycle, ready0 + data0=A5 at +3 clk.
//  req0,req1 held 8 cycles -> grants 0,1,0,1,...; each port gets 4 readies, correct bytes, in order.
//  Port 1 alone streams addrs 0..72 -> 73 ready1 pulses, contiguous, data matches RAM.
//  Force ram_read_ready with no grant -> err=1, no readyN; stays 1 until reset low.
//  Assert reset low with 2 reads in flight -> all outputs 0 immediately, no readyN after release.
//  PB_ARB_LOCK_EN: lock0=1,req0,req1 held 6 cycles -> 6 gnt0, 0 gnt1; drop lock0 -> gnt1 next.

Source files
------------

// File: rtl/packet_buffer_read_arbiter.sv
// packet_buffer_read_arbiter
//   Shares the single RAM read port between the Ethernet TX path (port 0) and
//   the UART dump (port 1). It grants round-robin, issues at most one read per
//   cycle and tags every read in flight, so that each returned byte goes back to
//   the port that asked for it.
//   Optional macro PB_ARB_LOCK_EN adds lock0/lock1. With a lock held, the port
//   that was granted last keeps its priority.
module packet_buffer_read_arbiter #(
    parameter int RAM_SIZE     = 128,
    parameter int READ_LATENCY = 2,
    parameter int WORD_LEN     = 8,
    localparam int AW          = $clog2(RAM_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [AW-1:0]       addr0,
    input  logic [AW-1:0]       addr1,
`ifdef PB_ARB_LOCK_EN
    input  logic                lock0,
    input  logic                lock1,
`endif
    output logic                gnt0,
    output logic                gnt1,
    output logic                ready0,
    output logic                ready1,
    output logic [WORD_LEN-1:0] data0,
    output logic [WORD_LEN-1:0] data1,
    output logic                ram_read_req,
    output logic [AW-1:0]       ram_read_addr,
    input  logic                ram_read_ready,
    input  logic [WORD_LEN-1:0] ram_read_out,
    output logic                err
);

    // last_q: the port granted most recently (1 after reset, so port 0 wins the first tie)
    logic last_q;
    logic pick0;

    // Tag pipe: stage 1 is loaded on the grant edge. The tail stage lines up
    // with ram_read_ready, which comes READ_LATENCY cycles later.
    logic [READ_LATENCY:1] vld_pipe;
    logic [READ_LATENCY:1] id_pipe;
    logic                  tail_vld;
    logic                  tail_id;

    assign tail_vld = vld_pipe[READ_LATENCY];
    assign tail_id  = id_pipe[READ_LATENCY];

    // Tie break: pick0 says which port wins when both are requesting
`ifdef PB_ARB_LOCK_EN
    assign pick0 = last_q ? !lock1 : lock0;
`else
    assign pick0 = last_q;
`endif

    // Grants are combinational. Reset blocks them so no read leaks out during reset.
    assign gnt0          = reset & req0 & (!req1 | pick0);
    assign gnt1          = reset & req1 & (!req0 | !pick0);
    assign ram_read_req  = gnt0 | gnt1;
    assign ram_read_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

    // Round-robin pointer follows every grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     last_q <= 1'b1;
        else if (gnt0)  last_q <= 1'b0;
        else if (gnt1)  last_q <= 1'b1;
    end

    // Tag shift register {valid, id}; it shifts every cycle whether or not there is a grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= ram_read_req;
            id_pipe[1]  <= gnt1;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // Return path: register the byte toward its issuer. The other port keeps its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            data0  <= '0;
            data1  <= '0;
        end else begin
            ready0 <= ram_read_ready & tail_vld & !tail_id;
            ready1 <= ram_read_ready & tail_vld & tail_id;
            if (ram_read_ready && tail_vld && !tail_id) data0 <= ram_read_out;
            if (ram_read_ready && tail_vld && tail_id)  data1 <= ram_read_out;
        end
    end

    // Sticky error: the driver's return timing does not match the tag pipe
    // (unexpected data, or a missing return)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        err <= 1'b0;
        else if (ram_read_ready != tail_vld) err <= 1'b1;
    end

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Bench for packet_buffer_read_arbiter: a RAM-driver model with fixed latency,
// and per-port scoreboards that check returned data and gnt->ready latency.
module tb_packet_buffer_read_arbiter;

    localparam int RS = 128;
    localparam int RL = 2;
    localparam int WL = 8;
    localparam int AW = $clog2(RS);

    typedef struct {
        logic [WL-1:0] d;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic          gnt0, gnt1, ready0, ready1, ram_read_req, ram_read_ready, err;
    logic [WL-1:0] data0, data1, ram_read_out;
    logic [AW-1:0] ram_read_addr;
    logic          force_rdy = 1'b0;

    logic [WL-1:0] mem [RS];
    logic [RL:1]   rv;
    logic [AW-1:0] ra [RL:1];

    int vectors = 0, miscompares = 0, cyc = 0;
    int rdy0_cnt = 0, rdy1_cnt = 0, run1 = 0, last1 = -10;
    exp_t q0[$], q1[$];

    packet_buffer_read_arbiter #(.RAM_SIZE(RS), .READ_LATENCY(RL), .WORD_LEN(WL)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
`ifdef PB_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .ready0(ready0), .ready1(ready1),
        .data0(data0), .data1(data1),
        .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
        .ram_read_ready(ram_read_ready), .ram_read_out(ram_read_out),
        .err(err)
    );

    always #10 clk = ~clk;

    // RAM driver model: it returns the data exactly RL cycles after each request
    always @(posedge clk) begin
        rv[1] <= ram_read_req;
        ra[1] <= ram_read_addr;
        for (int i = 2; i <= RL; i++) begin
            rv[i] <= rv[i-1];
            ra[i] <= ra[i-1];
        end
    end
    assign ram_read_ready = rv[RL] | force_rdy;
    assign ram_read_out   = mem[ra[RL]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pushes on each grant, pops on each ready. It also checks the one-grant rule.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                q0.delete();
                q1.delete();
            end else begin
                vectors++;
                if (gnt0 && gnt1) begin
                    miscompares++;
                    $display("FAIL one_grant: gnt0=%b gnt1=%b, want at most one", gnt0, gnt1);
                end
                if (ready0) begin
                    vectors++;
                    rdy0_cnt++;
                    if (q0.size() == 0) begin
                        miscompares++;
                        $display("FAIL ready0_unexpected: ready0=1 at cycle %0d, want none", cyc);
                    end else begin
                        e = q0.pop_front();
                        if (data0 !== e.d || cyc != e.c + RL + 1) begin
                            miscompares++;
                            $display("FAIL ready0_data: data0=%h cyc=%0d, want %h cyc=%0d", data0, cyc, e.d, e.c + RL + 1);
                        end
                    end
                end
                if (ready1) begin
                    vectors++;
                    rdy1_cnt++;
                    run1  = (last1 == cyc - 1) ? run1 + 1 : 1;
                    last1 = cyc;
                    if (q1.size() == 0) begin
                        miscompares++;
                        $display("FAIL ready1_unexpected: ready1=1 at cycle %0d, want none", cyc);
                    end else begin
                        e = q1.pop_front();
                        if (data1 !== e.d || cyc != e.c + RL + 1) begin
                            miscompares++;
                            $display("FAIL ready1_data: data1=%h cyc=%0d, want %h cyc=%0d", data1, cyc, e.d, e.c + RL + 1);
                        end
                    end
                end
                if (gnt0) q0.push_back('{d: mem[addr0], c: cyc});
                if (gnt1) q1.push_back('{d: mem[addr1], c: cyc});
            end
        end
    endtask

    task automatic test_reset();
        req0 = 1'b1; addr0 = 7'd3;
        repeat (3) tick();
        vectors++;
        if ({gnt0, gnt1, ready0, ready1, ram_read_req, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: {gnt0,gnt1,rdy0,rdy1,req,err}=%b, want 000000", {gnt0, gnt1, ready0, ready1, ram_read_req, err});
        end
        vectors++;
        if (data0 !== '0 || data1 !== '0 || ram_read_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_data: data0=%h data1=%h addr=%h, want 0", data0, data1, ram_read_addr);
        end
        req0 = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int b0;
        b0 = rdy0_cnt;
        tick();
        req0 = 1'b1; addr0 = 7'd5;
        #1;
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_read_addr !== 7'd5) begin
            miscompares++;
            $display("FAIL single_gnt: gnt0=%b gnt1=%b addr=%0d, want 1 0 5", gnt0, gnt1, ram_read_addr);
        end
        tick();
        req0 = 1'b0;
        repeat (5) tick();
        vectors++;
        if (rdy0_cnt - b0 != 1 || data0 !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_ret: readies=%0d data0=%h, want 1 a5", rdy0_cnt - b0, data0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, b1, n0, n1;
        b0 = rdy0_cnt; b1 = rdy1_cnt; n0 = 0; n1 = 0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            req0 = 1'b1; req1 = 1'b1;
            addr0 = AW'(10 + n0); addr1 = AW'(40 + n1);
            @(negedge clk);
            vectors++;
            if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL alternate[%0d]: gnt0=%b gnt1=%b, want port %0d", k, gnt0, gnt1, k % 2);
            end
            if (gnt0) n0++;
            if (gnt1) n1++;
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) tick();
        vectors++;
        if (rdy0_cnt - b0 != 4 || rdy1_cnt - b1 != 4) begin
            miscompares++;
            $display("FAIL alternate_count: ready0=%0d ready1=%0d, want 4 4", rdy0_cnt - b0, rdy1_cnt - b1);
        end
    endtask

    task automatic test_stream();
        int b1, miss;
        b1 = rdy1_cnt; miss = 0;
        for (int i = 0; i <= 72; i++) begin
            tick();
            req1 = 1'b1; addr1 = AW'(i);
            @(negedge clk);
            if (gnt1 !== 1'b1) miss++;
        end
        tick();
        req1 = 1'b0;
        repeat (5) tick();
        vectors++;
        if (miss != 0) begin
            miscompares++;
            $display("FAIL stream_gnt: %0d cycles without gnt1, want 0", miss);
        end
        vectors++;
        if (rdy1_cnt - b1 != 73 || run1 != 73) begin
            miscompares++;
            $display("FAIL stream_ready: count=%0d run=%0d, want 73 73", rdy1_cnt - b1, run1);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_err: err=%b, want 0", err);
        end
    endtask

`ifdef PB_ARB_LOCK_EN
    task automatic test_lock();
        int g0;
        g0 = 0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1;
            addr0 = AW'(20 + k); addr1 = 7'd60;
            @(negedge clk);
            if (gnt0 === 1'b1 && gnt1 === 1'b0) g0++;
        end
        vectors++;
        if (g0 != 6) begin
            miscompares++;
            $display("FAIL lock_hold: gnt0 cycles=%0d, want 6", g0);
        end
        tick();
        lock0 = 1'b0;
        @(negedge clk);
        vectors++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_release: gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) tick();
    endtask
`endif

    task automatic test_err();
        tick();
        force_rdy = 1'b1;
        tick();
        force_rdy = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set: err=%b, want 1", err);
        end
        repeat (4) tick();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: err=%b, want 0", err);
        end
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int b0;
        b0 = rdy0_cnt;
        tick();
        req0 = 1'b1; addr0 = 7'd1;
        tick();
        addr0 = 7'd2;
        tick();
        req0 = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if ({gnt0, gnt1, ready0, ready1, ram_read_req, err} !== 6'b0 || data0 !== '0 || data1 !== '0) begin
            miscompares++;
            $display("FAIL midflight_reset: ctrl=%b data0=%h data1=%h, want 0", {gnt0, gnt1, ready0, ready1, ram_read_req, err}, data0, data1);
        end
        repeat (4) tick();
        reset = 1'b1;
        repeat (6) tick();
        vectors++;
        if (rdy0_cnt != b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_after: readies=%0d err=%b, want 0 0", rdy0_cnt - b0, err);
        end
    endtask

    initial begin
        for (int i = 0; i < RS; i++) mem[i] = WL'(i * 37 + 11);
        mem[5] = 8'hA5;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
`ifdef PB_ARB_LOCK_EN
        test_lock();
`endif
        test_err();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
